// File: rtl/team_06_i2s_tx.sv
// I2S transmitter: buffers 8-bit ADC samples in a small FIFO, converts offset binary
// to two's complement and plays each sample into both the left and right slot.
module team_06_i2s_tx #(
    parameter int DEPTH       = 4,
    parameter int SLOT_BITS   = 16,
    parameter int BCLK_DIV    = 2,
    parameter int SIGNED_CONV = 1
) (
    input  logic                   spiclk,
    input  logic                   rst,
    input  logic [7:0]             sample_in,
    input  logic                   sample_valid,
    input  logic                   en,
    input  logic                   clr_flags,
    output logic                   bclk,
    output logic                   ws,
    output logic                   sd,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int PW = $clog2(2 * SLOT_BITS);
    localparam int CW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(2 * SLOT_BITS - 1);
    localparam logic [CW-1:0] C_LAST = CW'(BCLK_DIV - 1);

    logic [CW-1:0] div_cnt;
    logic          div_wrap;
    logic          fall_evt;
    logic [PW-1:0] pos;
    logic [PW-1:0] pos_next;
    logic          fetch;
    logic          ws_next;
    logic          sd_next;
    logic [2:0]    left_idx;
    logic [2:0]    right_idx;
    logic [7:0]    frame;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic [7:0]    head_conv;

    // bclk falls when the divider wraps while bclk is high; everything else keys off that.
    assign div_wrap = en && (div_cnt == C_LAST);
    assign fall_evt = div_wrap && bclk;
    assign pos_next = (pos == P_LAST) ? '0 : pos + 1'b1;
    assign fetch    = fall_evt && (pos == P_LAST);

    // sample_valid is a one-cycle strobe with no back-pressure: a push is taken whenever
    // there is room (or room is made by a pop in the same cycle), otherwise it is dropped.
    assign empty = (fifo_level == '0);
    assign full  = (fifo_level == LW'(DEPTH));
    assign pop   = fetch && !empty;
    assign push  = sample_valid && (!full || pop);

    assign head_conv = (SIGNED_CONV != 0) ? {~mem[rd_ptr][7], mem[rd_ptr][6:0]} : mem[rd_ptr];

    assign ws_next   = (pos_next >= PW'(SLOT_BITS));
    assign left_idx  = 3'(PW'(8) - pos_next);
    assign right_idx = 3'(PW'(SLOT_BITS + 8) - pos_next);

    always_comb begin
        sd_next = 1'b0;
        if ((pos_next >= PW'(1)) && (pos_next <= PW'(8))) begin
            sd_next = frame[left_idx];
        end else if ((pos_next >= PW'(SLOT_BITS + 1)) && (pos_next <= PW'(SLOT_BITS + 8))) begin
            sd_next = frame[right_idx];
        end
    end

    always_ff @(posedge spiclk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (en) begin
            div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
            if (div_wrap) begin
                bclk <= ~bclk;
            end
        end
    end

    always_ff @(posedge spiclk or posedge rst) begin
        if (rst) begin
            pos <= P_LAST;
            ws  <= 1'b0;
            sd  <= 1'b0;
        end else if (fall_evt) begin
            pos <= pos_next;
            ws  <= ws_next;
            sd  <= sd_next;
        end
    end

    // An empty FIFO at frame start plays a silent frame.
    always_ff @(posedge spiclk or posedge rst) begin
        if (rst) begin
            frame <= '0;
        end else if (fetch) begin
            frame <= pop ? head_conv : '0;
        end
    end

    always_ff @(posedge spiclk) begin
        if (push) begin
            mem[wr_ptr] <= sample_in;
        end
    end

    always_ff @(posedge spiclk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // A set in the same cycle as clr_flags wins.
    always_ff @(posedge spiclk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (sample_valid && full && !pop) || (overflow && !clr_flags);
            underflow <= (fetch && empty) || (underflow && !clr_flags);
        end
    end

endmodule

// File: tb/tb_team_06_i2s_tx.sv
// Bench for team_06_i2s_tx: a signed and an unsigned instance share stimulus; a queue-based
// reference model checks every cycle, plus table vectors and hand-written corner sequences.
module tb_team_06_i2s_tx;

    localparam int DEPTH     = 4;
    localparam int SLOT_BITS = 16;
    localparam int BCLK_DIV  = 2;
    localparam int LW        = $clog2(DEPTH) + 1;
    localparam int FRAME     = 2 * SLOT_BITS;

    logic          spiclk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    sample_in = '0;
    logic          sample_valid = 1'b0;
    logic          en = 1'b0;
    logic          clr_flags = 1'b0;

    logic          bclk1, ws1, sd1, of1, uf1;
    logic [LW-1:0] lvl1;
    logic          bclk0, ws0, sd0, of0, uf0;
    logic [LW-1:0] lvl0;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];

    typedef struct {
        logic [7:0] sample;
        logic [7:0] exp_c1;
        logic [7:0] exp_c0;
    } vec_t;
    vec_t vecs[5];

    always #5 spiclk = ~spiclk;

    team_06_i2s_tx #(.DEPTH(DEPTH), .SLOT_BITS(SLOT_BITS), .BCLK_DIV(BCLK_DIV), .SIGNED_CONV(1)) dut_c1 (
        .spiclk(spiclk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
        .en(en), .clr_flags(clr_flags), .bclk(bclk1), .ws(ws1), .sd(sd1),
        .fifo_level(lvl1), .overflow(of1), .underflow(uf1)
    );

    team_06_i2s_tx #(.DEPTH(DEPTH), .SLOT_BITS(SLOT_BITS), .BCLK_DIV(BCLK_DIV), .SIGNED_CONV(0)) dut_c0 (
        .spiclk(spiclk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
        .en(en), .clr_flags(clr_flags), .bclk(bclk0), .ws(ws0), .sd(sd0),
        .fifo_level(lvl0), .overflow(of0), .underflow(uf0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model: a count of enabled cycles, a byte queue and the current frame bytes.
    int         m_n = 0;
    logic [7:0] m_q[$];
    logic [7:0] m_f1 = '0;
    logic [7:0] m_f0 = '0;
    logic       m_uf = 1'b0;
    logic       m_of = 1'b0;

    function automatic logic sd_of(input logic [7:0] x, input int p);
        if (p >= 1 && p <= 8) return x[8-p];
        if (p >= SLOT_BITS + 1 && p <= SLOT_BITS + 8) return x[SLOT_BITS+8-p];
        return 1'b0;
    endfunction

    function automatic logic [FRAME-1:0] frame_word(input logic [7:0] x);
        logic [FRAME-1:0] w;
        w = '0;
        for (int p = 1; p <= 8; p++) begin
            w[p]             = x[8-p];
            w[SLOT_BITS + p] = x[8-p];
        end
        return w;
    endfunction

    task automatic compare_outputs();
        int f;
        int p;
        logic e_ws;
        f    = m_n / (2 * BCLK_DIV);
        p    = (FRAME - 1 + f) % FRAME;
        e_ws = (f > 0) && (p >= SLOT_BITS);
        check("m_bclk_c1", bclk1, 32'((m_n / BCLK_DIV) % 2));
        check("m_ws_c1", ws1, e_ws);
        check("m_sd_c1", sd1, sd_of(m_f1, p));
        check("m_level_c1", lvl1, m_q.size());
        check("m_overflow_c1", of1, m_of);
        check("m_underflow_c1", uf1, m_uf);
        check("m_bclk_c0", bclk0, 32'((m_n / BCLK_DIV) % 2));
        check("m_ws_c0", ws0, e_ws);
        check("m_sd_c0", sd0, sd_of(m_f0, p));
        check("m_level_c0", lvl0, m_q.size());
        check("m_overflow_c0", of0, m_of);
        check("m_underflow_c0", uf0, m_uf);
    endtask

    always @(posedge spiclk) begin : model
        int         p;
        logic       fall, fetch, was_empty, was_full, popped, uf_set, of_set;
        logic [7:0] x;
        if (rst) begin
            m_n = 0;
            m_q.delete();
            m_f1 = '0;
            m_f0 = '0;
            m_uf = 1'b0;
            m_of = 1'b0;
        end else begin
            fall = en && (((m_n + 1) % (2 * BCLK_DIV)) == 0);
            if (en) m_n++;
            p         = (FRAME - 1 + m_n / (2 * BCLK_DIV)) % FRAME;
            fetch     = fall && (p == 0);
            was_empty = (m_q.size() == 0);
            was_full  = (m_q.size() == DEPTH);
            popped    = 1'b0;
            uf_set    = 1'b0;
            of_set    = 1'b0;
            if (fetch) begin
                if (!was_empty) begin
                    x      = m_q.pop_front();
                    m_f1   = x ^ 8'h80;
                    m_f0   = x;
                    popped = 1'b1;
                end else begin
                    m_f1   = '0;
                    m_f0   = '0;
                    uf_set = 1'b1;
                end
            end
            if (sample_valid) begin
                if (!was_full || popped) m_q.push_back(sample_in);
                else of_set = 1'b1;
            end
            m_uf = uf_set || (m_uf && !clr_flags);
            m_of = of_set || (m_of && !clr_flags);
        end
        #1;
        compare_outputs();
    end

    task automatic do_reset();
        @(negedge spiclk);
        rst          = 1'b1;
        en           = 1'b0;
        sample_valid = 1'b0;
        clr_flags    = 1'b0;
        @(negedge spiclk);
        @(negedge spiclk);
        rst = 1'b0;
    endtask

    task automatic push(input logic [7:0] x);
        @(negedge spiclk);
        sample_in    = x;
        sample_valid = 1'b1;
        @(negedge spiclk);
        sample_valid = 1'b0;
    endtask

    task automatic wait_rise();
        logic prev;
        prev = bclk1;
        for (int k = 0; k < 8 * BCLK_DIV; k++) begin
            @(negedge spiclk);
            if (bclk1 && !prev) return;
            prev = bclk1;
        end
        check("bclk_rise_timeout", 32'd0, 32'd1);
    endtask

    task automatic capture_frame(output logic [FRAME-1:0] w1, output logic [FRAME-1:0] w0);
        for (int i = 0; i < FRAME; i++) begin
            wait_rise();
            w1[i] = sd1;
            w0[i] = sd0;
        end
    endtask

    task automatic check_frames(input int n, input string tag);
        logic [FRAME-1:0] w1, w0;
        logic [15:0]      e;
        for (int k = 0; k < n; k++) begin
            capture_frame(w1, w0);
            if (exp_q.size() == 0) begin
                check($sformatf("%s_exp_q_empty", tag), 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("%s_c1_frame%0d", tag, k), w1, frame_word(e[15:8]));
                check($sformatf("%s_c0_frame%0d", tag, k), w0, frame_word(e[7:0]));
            end
        end
    endtask

    task automatic wait_ws_fall(output int cycles);
        logic prev;
        prev   = ws1;
        cycles = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge spiclk);
            cycles++;
            if (!ws1 && prev) return;
            prev = ws1;
        end
        check("ws_fall_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [7:0] s[6];
        logic [7:0] x;
        int         cyc;
        int         first_rise;
        int         rate;

        vecs[0] = '{8'hA5, 8'h25, 8'hA5};
        vecs[1] = '{8'h80, 8'h00, 8'h80};
        vecs[2] = '{8'h00, 8'h80, 8'h00};
        vecs[3] = '{8'hFF, 8'h7F, 8'hFF};
        vecs[4] = '{8'h3C, 8'hBC, 8'h3C};

        // Reset state.
        @(negedge spiclk);
        check("rst_bclk", bclk1, 32'd0);
        check("rst_ws", ws1, 32'd0);
        check("rst_sd", sd1, 32'd0);
        check("rst_level", lvl1, 32'd0);
        check("rst_overflow", of1, 32'd0);
        check("rst_underflow", uf1, 32'd0);

        // Table: one sample into an empty FIFO, decode the first frame.
        foreach (vecs[v]) begin
            do_reset();
            push(vecs[v].sample);
            check($sformatf("tbl%0d_level", v), lvl1, 32'd1);
            en = 1'b1;
            wait_rise();
            exp_q.push_back({vecs[v].exp_c1, vecs[v].exp_c0});
            check_frames(1, $sformatf("tbl%0d", v));
        end

        // Asynchronous reset in the middle of a running stream.
        push(8'h11);
        push(8'h22);
        push(8'h33);
        repeat (9) @(negedge spiclk);
        @(posedge spiclk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_bclk", bclk1, 32'd0);
        check("arst_ws", ws1, 32'd0);
        check("arst_sd", sd1, 32'd0);
        check("arst_level", lvl1, 32'd0);
        check("arst_overflow", of1, 32'd0);
        check("arst_underflow", uf1, 32'd0);
        @(negedge spiclk);
        @(negedge spiclk);
        rst        = 1'b0;
        first_rise = 0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge spiclk);
            #2;
            if (bclk1 && first_rise == 0) first_rise = k;
        end
        check("arst_first_rise_edge", first_rise, 32'd2);

        // Underflow, clear, frame length, re-set at the next frame start.
        do_reset();
        en = 1'b1;
        repeat (5) @(negedge spiclk);
        check("uf_after_first_fetch", uf1, 32'd1);
        clr_flags = 1'b1;
        @(negedge spiclk);
        clr_flags = 1'b0;
        check("uf_cleared", uf1, 32'd0);
        wait_ws_fall(cyc);
        check("uf_set_again", uf1, 32'd1);
        wait_ws_fall(cyc);
        check("frame_length", cyc, 32'd128);

        // Overflow: six pushes before the first fetch, only four survive.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            s[i] = 8'($urandom_range(0, 255));
            push(s[i]);
            repeat (6) @(negedge spiclk);
        end
        check("ovf_level", lvl1, 32'd4);
        check("ovf_flag", of1, 32'd1);
        for (int i = 0; i < 4; i++) exp_q.push_back({s[i] ^ 8'h80, s[i]});
        exp_q.push_back(16'h0000);
        en = 1'b1;
        wait_rise();
        check_frames(5, "ovf");
        check("ovf_sticky", of1, 32'd1);

        // Full FIFO, push coincident with fetch.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            s[i] = 8'($urandom_range(0, 255));
            push(s[i]);
        end
        check("full_level", lvl1, 32'd4);
        en = 1'b1;
        repeat (3) @(negedge spiclk);
        x            = 8'($urandom_range(0, 255));
        sample_in    = x;
        sample_valid = 1'b1;
        @(negedge spiclk);
        sample_valid = 1'b0;
        check("full_fetch_level", lvl1, 32'd4);
        check("full_fetch_overflow", of1, 32'd0);
        for (int i = 0; i < 4; i++) exp_q.push_back({s[i] ^ 8'h80, s[i]});
        exp_q.push_back({x ^ 8'h80, x});
        check_frames(5, "fullfetch");

        // Empty FIFO, push coincident with fetch.
        do_reset();
        en = 1'b1;
        repeat (3) @(negedge spiclk);
        x            = 8'($urandom_range(0, 255));
        sample_in    = x;
        sample_valid = 1'b1;
        @(negedge spiclk);
        sample_valid = 1'b0;
        check("empty_fetch_underflow", uf1, 32'd1);
        check("empty_fetch_level", lvl1, 32'd1);
        exp_q.push_back(16'h0000);
        exp_q.push_back({x ^ 8'h80, x});
        check_frames(2, "emptyfetch");

        // Random traffic against the model, alternating busy and sparse push rates.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 0) rate = $urandom_range(1, 12);
            @(negedge spiclk);
            en           = ($urandom_range(0, 9) != 0);
            sample_valid = ($urandom_range(0, 199) < rate);
            sample_in    = 8'($urandom);
            clr_flags    = ($urandom_range(0, 63) == 0);
        end
        @(negedge spiclk);
        sample_valid = 1'b0;
        clr_flags    = 1'b0;
        repeat (4) @(negedge spiclk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
